eei_unit_sched: RTL and testbench

- Sequences custom-instruction (EEI) requests from the core onto a set of N_UNIT custom execution units, such as the fast-GPIO and snapshot-register units.
- Decodes funct3 to pick one target unit and drives a level request to it.
- Waits for the unit's ack with a timeout watchdog, then returns a single registered ack/error/rd_op response to the core.
- Sits between the core EEI port and the custom units. It replaces the purely combinational ack steering with a controlled, observable handshake.

---
 rtl/eei_unit_sched.sv | 153 +++++++++++++++
 tb/tb_eei_unit_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/eei_unit_sched.sv
// EEI request scheduler: steers one core custom-instruction request onto one
// of N_UNIT execution units, waits for that unit's ack under a watchdog, and
// returns a single registered ack/error/rd_op pulse to the core.
//
// state | meaning
// IDLE  | waiting for eei_req; decodes funct3 against N_UNIT and unit_en
// WAIT  | unit_req[sel] held high; counting toward the timeout
// RESP  | eei_ack pulse cycle; returns to IDLE unconditionally
module eei_unit_sched #(
  parameter int N_UNIT  = 4,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  eei_req,
  input  logic [2:0]            eei_funct3,
  output logic                  eei_ack,
  output logic                  eei_error,
  output logic [1:0]            eei_rd_op,
  input  logic [N_UNIT-1:0]     unit_en,
  output logic [N_UNIT-1:0]     unit_req,
  input  logic [N_UNIT-1:0]     unit_ack,
  input  logic [N_UNIT-1:0]     unit_error,
  input  logic [2*N_UNIT-1:0]   unit_rd_op,
  output logic                  busy,
  output logic [7:0]            timeout_cnt,
  output logic [2:0]            last_to_unit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_UNIT-1:0]   unit_req_d;
  logic                ack_d, err_d, busy_d;
  logic [1:0]          rd_op_d;
  logic [7:0]          to_cnt_d;
  logic [2:0]          last_to_d;

  logic                req_mapped;
  logic                sel_ack, sel_err;
  logic [1:0]          sel_rd_op;

  // Decode the incoming funct3 and mux the selected unit's response lines.
  // Loops compare against each index so funct3 values >= N_UNIT never index
  // past the end of the unit vectors.
  always_comb begin
    req_mapped = 1'b0;
    sel_ack    = 1'b0;
    sel_err    = 1'b0;
    sel_rd_op  = 2'b00;
    for (int i = 0; i < N_UNIT; i++) begin
      if (eei_funct3 == 3'(i)) req_mapped = unit_en[i];
      if (sel_q == 3'(i)) begin
        sel_ack   = unit_ack[i];
        sel_err   = unit_error[i];
        sel_rd_op = unit_rd_op[2*i +: 2];
      end
    end
  end

  // Next-state and next-output logic; every output is computed here and
  // registered below, so unit_* never reaches eei_* combinationally.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    unit_req_d = '0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rd_op_d    = 2'b00;
    to_cnt_d   = timeout_cnt;
    last_to_d  = last_to_unit;
    case (state_q)
      S_IDLE: begin
        if (eei_req) begin
          if (req_mapped) begin
            sel_d   = eei_funct3;
            cnt_d   = '0;
            state_d = S_WAIT;
            for (int i = 0; i < N_UNIT; i++) begin
              unit_req_d[i] = (eei_funct3 == 3'(i));
            end
          end else begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Ack takes priority over a watchdog expiring in the same cycle.
        if (sel_ack) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          err_d   = sel_err;
          rd_op_d = sel_err ? 2'b00 : sel_rd_op;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = S_RESP;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          last_to_d = sel_q;
          if (timeout_cnt != 8'hFF) to_cnt_d = timeout_cnt + 8'd1;
        end else begin
          unit_req_d = unit_req;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears unit_req immediately so an
  // in-flight unit request is withdrawn as soon as reset asserts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      sel_q        <= 3'd0;
      cnt_q        <= '0;
      unit_req     <= '0;
      eei_ack      <= 1'b0;
      eei_error    <= 1'b0;
      eei_rd_op    <= 2'b00;
      busy         <= 1'b0;
      timeout_cnt  <= 8'd0;
      last_to_unit <= 3'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      unit_req     <= unit_req_d;
      eei_ack      <= ack_d;
      eei_error    <= err_d;
      eei_rd_op    <= rd_op_d;
      busy         <= busy_d;
      timeout_cnt  <= to_cnt_d;
      last_to_unit <= last_to_d;
    end
  end

endmodule

// File: tb/tb_eei_unit_sched.sv
// Scoreboard bench for eei_unit_sched: the driver predicts each response from
// the request/unit plan, a monitor pops and checks on every eei_ack.
module tb_eei_unit_sched;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int NEVER = 1000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            eei_req;
  logic [2:0]      eei_funct3;
  logic            eei_ack, eei_error;
  logic [1:0]      eei_rd_op;
  logic [N-1:0]    unit_en, unit_req, unit_ack, unit_error;
  logic [2*N-1:0]  unit_rd_op;
  logic            busy;
  logic [7:0]      timeout_cnt;
  logic [2:0]      last_to_unit;

  eei_unit_sched #(.N_UNIT(N), .TIMEOUT(TO), .CW(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .eei_req(eei_req), .eei_funct3(eei_funct3),
    .eei_ack(eei_ack), .eei_error(eei_error), .eei_rd_op(eei_rd_op),
    .unit_en(unit_en), .unit_req(unit_req), .unit_ack(unit_ack),
    .unit_error(unit_error), .unit_rd_op(unit_rd_op), .busy(busy),
    .timeout_cnt(timeout_cnt), .last_to_unit(last_to_unit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [1:0] rd;
    int         cyc;
    int         reqc;
    logic [3:0] mask;
    logic [7:0] toc;
    logic [2:0] last;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int to_m = 0;
  logic [2:0] last_m = 3'd0;

  // unit responder plan
  int plan_d = NEVER;
  logic plan_err = 1'b0;
  logic [1:0] plan_rd = 2'b00;
  bit spurious = 1'b0;
  int wait_idx = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unit model: acks plan_d cycles after the request appears; noise elsewhere.
  initial begin
    logic [N-1:0] a, e;
    logic [2*N-1:0] r;
    unit_ack = '0; unit_error = '0; unit_rd_op = '0;
    forever begin
      @(negedge clk);
      a = spurious ? (4'($urandom) & ~unit_req) : 4'b0;
      e = 4'($urandom);
      r = 8'($urandom);
      if (unit_req != 0) begin
        for (int i = 0; i < N; i++) begin
          if (unit_req[i]) begin
            a[i] = (wait_idx == plan_d);
            e[i] = plan_err;
            r[2*i +: 2] = plan_rd;
          end
        end
        wait_idx++;
      end else begin
        wait_idx = 0;
      end
      unit_ack = a; unit_error = e; unit_rd_op = r;
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on each eei_ack.
  initial begin
    int req_c, busy_c;
    logic [3:0] mask;
    exp_t x;
    req_c = 0; busy_c = 0; mask = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_c = 0; busy_c = 0; mask = '0;
      end else begin
        if (!$onehot0(unit_req)) chk("req_onehot", unit_req, 0);
        if (!busy && unit_req != 0) chk("req_while_idle", unit_req, 0);
        if (unit_req != 0) req_c++;
        mask |= unit_req;
        if (busy) busy_c++;
        if (eei_ack) begin
          if (q.size() == 0) begin
            chk("unexpected_ack", eei_ack, 0);
          end else begin
            x = q.pop_front();
            chk("ack_cycle", cyc, x.cyc);
            chk("eei_error", eei_error, x.err);
            chk("eei_rd_op", eei_rd_op, x.rd);
            chk("unit_req_cycles", req_c, x.reqc);
            chk("unit_req_mask", mask, x.mask);
            chk("busy_cycles", busy_c, x.reqc + 1);
            chk("timeout_cnt", timeout_cnt, x.toc);
            chk("last_to_unit", last_to_unit, x.last);
          end
          req_c = 0; busy_c = 0; mask = '0;
        end
      end
    end
  end

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  endtask

  // One core instruction; called at a negedge, returns at the ack negedge.
  task automatic do_op(input logic [2:0] f, input logic [3:0] en, input int d,
                       input logic e, input logic [1:0] rd, input bit flush,
                       input bit spur);
    exp_t x;
    bit mapped, acked;
    @(negedge clk);
    plan_d = d; plan_err = e; plan_rd = rd; spurious = spur;
    unit_en = en; eei_funct3 = f; eei_req = 1'b1;
    mapped = (f < 3'(N)) ? en[f[1:0]] : 1'b0;
    x.cyc = cyc + 1;
    if (!mapped) begin
      x.err = 1'b1; x.rd = 2'b00; x.reqc = 0; x.mask = '0;
    end else if (d <= TO - 1) begin
      x.err = e; x.rd = e ? 2'b00 : rd; x.cyc += 1 + d; x.reqc = d + 1;
      x.mask = 4'b0001 << f[1:0];
    end else begin
      x.err = 1'b1; x.rd = 2'b00; x.cyc += TO; x.reqc = TO;
      x.mask = 4'b0001 << f[1:0];
      if (to_m < 255) to_m++;
      last_m = f;
    end
    x.toc = 8'(to_m); x.last = last_m;
    q.push_back(x);
    acked = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0 && mapped) begin
        unit_en = 4'($urandom);
        if (flush) eei_req = 1'b0;
      end
      if (eei_ack) begin acked = 1'b1; break; end
    end
    if (!acked) begin
      chk("ack_watchdog", 0, 1);
      finish_run();
    end
    if ($urandom_range(0, 1) == 0) eei_req = 1'b0;
  endtask

  task automatic idle(input int n);
    eei_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; eei_req = 1'b0; eei_funct3 = 3'd0; unit_en = '1;
    repeat (2) @(negedge clk);
    chk("rst_eei_ack", eei_ack, 0);
    chk("rst_eei_error", eei_error, 0);
    chk("rst_eei_rd_op", eei_rd_op, 0);
    chk("rst_unit_req", unit_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_cnt", timeout_cnt, 0);
    chk("rst_last_to_unit", last_to_unit, 0);
    rst_n = 1'b1;
    idle(2);

    do_op(3'd1, 4'b1111, 1, 1'b0, 2'd1, 1'b0, 1'b0);
    idle(1);
    do_op(3'd5, 4'b1111, 0, 1'b0, 2'd3, 1'b0, 1'b0);
    do_op(3'd2, 4'b1011, 0, 1'b0, 2'd3, 1'b0, 1'b0);
    idle(1);
    do_op(3'd3, 4'b1111, NEVER, 1'b0, 2'd1, 1'b0, 1'b0);
    idle(1);
    do_op(3'd2, 4'b1111, TO - 1, 1'b0, 2'd2, 1'b0, 1'b1);
    idle(2);
    do_op(3'd0, 4'b1111, 0, 1'b0, 2'd1, 1'b0, 1'b0);
    do_op(3'd1, 4'b1111, 0, 1'b0, 2'd2, 1'b0, 1'b0);
    do_op(3'd1, 4'b1111, 0, 1'b1, 2'd3, 1'b0, 1'b0);
    do_op(3'd0, 4'b1111, TO, 1'b0, 2'd3, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      do_op(3'($urandom_range(0, 7)), 4'($urandom), $urandom_range(0, TO + 2),
            ($urandom_range(0, 3) == 0), 2'($urandom),
            1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Reset in the middle of a WAIT: request drops at once, no ack afterwards.
    idle(1);
    plan_d = NEVER; spurious = 1'b0;
    unit_en = 4'b1111; eei_funct3 = 3'd2; eei_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_unit_req", unit_req, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_unit_req", unit_req, 0);
    chk("async_busy", busy, 0);
    chk("async_eei_ack", eei_ack, 0);
    to_m = 0; last_m = 3'd0;
    @(negedge clk);
    chk("rst_timeout_cnt_clr", timeout_cnt, 0);
    eei_req = 1'b0;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", busy, 0);

    for (int n = 0; n < 260; n++) begin
      do_op(3'($urandom_range(0, N - 1)), 4'b1111, NEVER, 1'b0, 2'd1, 1'b0, 1'b0);
    end
    idle(2);
    chk("timeout_saturated", timeout_cnt, 8'd255);
    chk("queue_drained", q.size(), 0);
    finish_run();
  end
endmodule
